// File: rtl/pmem_scheduler_pkg.sv
// Shared types for the physical-memory scheduler: FSM state encoding and
// the write-back buffer entry layout.
package types;

    localparam int LINE_W = 256;
    localparam int TAG_W  = 27;

    typedef enum logic [2:0] {
        IDLE,
        LOCAL_RESP,
        IREAD,
        DREAD,
        DRAIN
    } pmem_sched_state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] data;
    } wb_entry_t;

    // Line-aligned byte address for a buffer tag.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag);
        return {tag, 5'b0};
    endfunction

endpackage

// File: rtl/pmem_scheduler_wb_fifo.sv
// Dcache write-back buffer: a small circular FIFO of whole cache lines.
// It exposes the oldest entry for draining and a parallel tag lookup that
// returns the youngest matching entry so reads see the latest buffered write.
module wb_fifo
    import types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enq,
    input  wb_entry_t         i_enq_entry,
    input  logic              i_deq,
    input  logic [TAG_W-1:0]  i_lookup_tag,
    output logic              o_full,
    output logic              o_empty,
    output wb_entry_t         o_oldest,
    output logic              o_hit,
    output logic [LINE_W-1:0] o_hit_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == DEPTH - 1) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; the scheduler never enqueues and
    // dequeues in the same cycle, so the two are mutually exclusive here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_enq) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
            r_count  <= r_count + 1'b1;
        end else if (i_deq) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count  <= r_count - 1'b1;
        end
    end

    // Line storage; contents are only meaningful while counted as valid.
    always_ff @(posedge clk) begin
        if (i_enq) begin
            r_mem[r_wr_ptr] <= i_enq_entry;
        end
    end

    // Scan valid entries oldest-to-youngest so the last match (youngest) wins.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((k < int'(r_count)) &&
                (r_mem[PTR_W'((int'(r_rd_ptr) + k) % DEPTH)].tag == i_lookup_tag)) begin
                o_hit      = 1'b1;
                o_hit_data = r_mem[PTR_W'((int'(r_rd_ptr) + k) % DEPTH)].data;
            end
        end
    end

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_oldest = r_mem[r_rd_ptr];

endmodule

// File: rtl/pmem_scheduler.sv
// Arbitrates icache and dcache line traffic onto a single cacheline adaptor.
// Dcache writes are absorbed into a write-back buffer and acknowledged
// locally; reads that hit the buffer are served from it without going
// downstream; buffered lines drain in FIFO order when nothing else is pending.
module pmem_scheduler
    import types::*;
#(
    parameter int WB_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  ipmem_address,
    input  logic         ipmem_read,
    output logic [255:0] ipmem_rdata,
    output logic         ipmem_resp,
    input  logic [31:0]  dpmem_address,
    input  logic         dpmem_read,
    input  logic         dpmem_write,
    input  logic [255:0] dpmem_wdata,
    output logic [255:0] dpmem_rdata,
    output logic         dpmem_resp,
    output logic [31:0]  address_i,
    output logic         read_i,
    output logic         write_i,
    output logic [255:0] line_i,
    input  logic [255:0] line_o,
    input  logic         resp_o
);

    pmem_sched_state_t r_state;
    pmem_sched_state_t w_next;

    logic [TAG_W-1:0]  r_tag;
    logic [LINE_W-1:0] r_lr_data;
    logic              r_lr_dside;
    logic              r_lr_read;
    logic [LINE_W-1:0] r_irdata;
    logic [LINE_W-1:0] r_drdata;

    logic              w_load;
    logic [TAG_W-1:0]  w_ld_tag;
    logic              w_ld_dside;
    logic              w_ld_read;

    logic              w_enq;
    logic              w_deq;
    logic              w_full;
    logic              w_empty;
    logic              w_hit;
    logic [LINE_W-1:0] w_hit_data;
    logic [TAG_W-1:0]  w_lookup_tag;
    wb_entry_t         w_enq_entry;
    wb_entry_t         w_oldest;

    logic              w_iresp;
    logic              w_dresp;
    logic [LINE_W-1:0] w_irdata;
    logic [LINE_W-1:0] w_drdata;

    // A dcache read takes precedence, so look up its tag whenever it is asserted.
    assign w_lookup_tag = dpmem_read ? dpmem_address[31:5] : ipmem_address[31:5];
    assign w_enq_entry  = '{tag: dpmem_address[31:5], data: dpmem_wdata};

    wb_fifo #(
        .DEPTH(WB_DEPTH)
    ) u_wb_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_enq       (w_enq),
        .i_enq_entry (w_enq_entry),
        .i_deq       (w_deq),
        .i_lookup_tag(w_lookup_tag),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_oldest    (w_oldest),
        .o_hit       (w_hit),
        .o_hit_data  (w_hit_data)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, buffer control and downstream/requester outputs.
    always_comb begin
        w_next     = r_state;
        w_enq      = 1'b0;
        w_deq      = 1'b0;
        w_load     = 1'b0;
        w_ld_tag   = '0;
        w_ld_dside = 1'b0;
        w_ld_read  = 1'b0;
        address_i  = '0;
        read_i     = 1'b0;
        write_i    = 1'b0;
        line_i     = '0;
        w_iresp    = 1'b0;
        w_dresp    = 1'b0;
        w_irdata   = r_irdata;
        w_drdata   = r_drdata;
        case (r_state)
            IDLE: begin
                if (dpmem_write) begin
                    if (!w_full) begin
                        w_enq      = 1'b1;
                        w_load     = 1'b1;
                        w_ld_dside = 1'b1;
                        w_next     = LOCAL_RESP;
                    end else begin
                        // Write stays pending at the requester until a slot frees.
                        w_next = DRAIN;
                    end
                end else if (dpmem_read) begin
                    w_load     = 1'b1;
                    w_ld_tag   = dpmem_address[31:5];
                    w_ld_dside = 1'b1;
                    w_ld_read  = 1'b1;
                    w_next     = w_hit ? LOCAL_RESP : DREAD;
                end else if (ipmem_read) begin
                    w_load    = 1'b1;
                    w_ld_tag  = ipmem_address[31:5];
                    w_ld_read = 1'b1;
                    w_next    = w_hit ? LOCAL_RESP : IREAD;
                end else if (!w_empty) begin
                    w_next = DRAIN;
                end
            end
            LOCAL_RESP: begin
                if (r_lr_dside) begin
                    w_dresp = 1'b1;
                    if (r_lr_read) begin
                        w_drdata = r_lr_data;
                    end
                end else begin
                    w_iresp  = 1'b1;
                    w_irdata = r_lr_data;
                end
                w_next = IDLE;
            end
            IREAD: begin
                address_i = line_addr(r_tag);
                read_i    = 1'b1;
                if (resp_o) begin
                    w_iresp  = 1'b1;
                    w_irdata = line_o;
                    w_next   = IDLE;
                end
            end
            DREAD: begin
                address_i = line_addr(r_tag);
                read_i    = 1'b1;
                if (resp_o) begin
                    w_dresp  = 1'b1;
                    w_drdata = line_o;
                    w_next   = IDLE;
                end
            end
            DRAIN: begin
                address_i = line_addr(w_oldest.tag);
                write_i   = 1'b1;
                line_i    = w_oldest.data;
                if (resp_o) begin
                    w_deq  = 1'b1;
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Capture request context when leaving IDLE; hit data is snapshotted so
    // the local response is independent of later buffer activity.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_tag      <= w_ld_tag;
            r_lr_data  <= w_hit_data;
            r_lr_dside <= w_ld_dside;
            r_lr_read  <= w_ld_read;
        end
    end

    // Read-data holding registers: rdata only changes in a response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irdata <= '0;
            r_drdata <= '0;
        end else begin
            r_irdata <= w_irdata;
            r_drdata <= w_drdata;
        end
    end

    assign ipmem_resp  = w_iresp;
    assign dpmem_resp  = w_dresp;
    assign ipmem_rdata = w_irdata;
    assign dpmem_rdata = w_drdata;

endmodule

// File: tb/tb_pmem_scheduler.sv
// Directed bench for pmem_scheduler with WB_DEPTH = 2. The bench plays both
// caches and the cacheline adaptor; inputs change 1 time unit after a rising
// edge and outputs are sampled there as well.
module tb_pmem_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  ipmem_address;
    logic         ipmem_read;
    logic [255:0] ipmem_rdata;
    logic         ipmem_resp;
    logic [31:0]  dpmem_address;
    logic         dpmem_read;
    logic         dpmem_write;
    logic [255:0] dpmem_wdata;
    logic [255:0] dpmem_rdata;
    logic         dpmem_resp;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         resp_o;

    int n_chk = 0;
    int n_err = 0;
    int n_iresp = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_both = 0;
    int n_rw = 0;

    localparam logic [255:0] L1 = {8{32'h1111_2222}};
    localparam logic [255:0] L2 = {8{32'h3333_4444}};
    localparam logic [255:0] L3 = {8{32'h5555_6666}};
    localparam logic [255:0] W1 = {8{32'h0BAD_F00D}};
    localparam logic [255:0] AA = {32{8'hAA}};
    localparam logic [255:0] D5 = {32{8'h55}};
    localparam logic [255:0] D6 = {32{8'h66}};
    localparam logic [255:0] D7 = {32{8'h77}};
    localparam logic [255:0] B1 = {32{8'hB1}};
    localparam logic [255:0] B2 = {32{8'hB2}};
    localparam logic [255:0] CC = {32{8'hCC}};

    pmem_scheduler #(.WB_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .ipmem_address(ipmem_address),
        .ipmem_read   (ipmem_read),
        .ipmem_rdata  (ipmem_rdata),
        .ipmem_resp   (ipmem_resp),
        .dpmem_address(dpmem_address),
        .dpmem_read   (dpmem_read),
        .dpmem_write  (dpmem_write),
        .dpmem_wdata  (dpmem_wdata),
        .dpmem_rdata  (dpmem_rdata),
        .dpmem_resp   (dpmem_resp),
        .address_i    (address_i),
        .read_i       (read_i),
        .write_i      (write_i),
        .line_i       (line_i),
        .line_o       (line_o),
        .resp_o       (resp_o)
    );

    always #5 clk = ~clk;

    // Edge-sampled activity counters.
    always @(posedge clk) begin
        if (!rst) begin
            if (ipmem_resp) n_iresp++;
            if (read_i) n_rd++;
            if (write_i) n_wr++;
            if (ipmem_resp && dpmem_resp) n_both++;
            if (read_i && write_i) n_rw++;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int bad;
        int rd0;
        int wr0;

        rst = 1'b1;
        ipmem_address = '0; ipmem_read = 1'b0;
        dpmem_address = '0; dpmem_read = 1'b0; dpmem_write = 1'b0; dpmem_wdata = '0;
        line_o = '0; resp_o = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_address_i", address_i, 0);
        chk("rst_read_i", read_i, 0);
        chk("rst_write_i", write_i, 0);
        chk("rst_line_i", line_i, 0);
        chk("rst_resps", {ipmem_resp, dpmem_resp}, 0);
        chk("rst_irdata", ipmem_rdata, 0);
        chk("rst_drdata", dpmem_rdata, 0);

        // Simultaneous reads: dcache first, then icache; icache stalled 10 cycles.
        ipmem_read = 1'b1; ipmem_address = 32'h100;
        dpmem_read = 1'b1; dpmem_address = 32'h2000;
        step();
        chk("prio_read_i", read_i, 1);
        chk("prio_addr_d", address_i, 32'h2000);
        chk("prio_write_i", write_i, 0);
        step(); step();
        chk("dread_hold", {read_i, address_i}, {1'b1, 32'h2000});
        resp_o = 1'b1; line_o = L1; #1;
        chk("dread_resp", dpmem_resp, 1);
        chk("dread_data", dpmem_rdata, L1);
        chk("dread_no_iresp", ipmem_resp, 0);
        dpmem_read = 1'b0;
        step();
        resp_o = 1'b0; line_o = '0;
        chk("drdata_hold", dpmem_rdata, L1);
        chk("dresp_one_cycle", dpmem_resp, 0);
        step();
        chk("iread_addr", address_i, 32'h100);
        chk("iread_read_i", read_i, 1);
        n0 = n_iresp; bad = 0;
        repeat (10) begin
            step();
            if (address_i !== 32'h100 || read_i !== 1'b1 || write_i !== 1'b0 || ipmem_resp !== 1'b0) bad++;
        end
        chk("iread_stall_stable", bad, 0);
        resp_o = 1'b1; line_o = L2; #1;
        chk("iresp", ipmem_resp, 1);
        chk("irdata", ipmem_rdata, L2);
        ipmem_read = 1'b0;
        step();
        resp_o = 1'b0; line_o = '0;
        chk("iresp_once", n_iresp - n0, 1);

        // Write into empty buffer: local ack, then drain when idle.
        dpmem_write = 1'b1; dpmem_address = 32'h3020; dpmem_wdata = W1; #1;
        chk("wr_no_early_resp", dpmem_resp, 0);
        step();
        chk("wr_local_resp", dpmem_resp, 1);
        chk("wr_no_down", {read_i, write_i}, 0);
        dpmem_write = 1'b0;
        step();
        chk("wr_resp_pulse", dpmem_resp, 0);
        chk("wr_idle_no_down", write_i, 0);
        step();
        chk("drain_write_i", write_i, 1);
        chk("drain_read_i", read_i, 0);
        chk("drain_addr", address_i, 32'h3020);
        chk("drain_line", line_i, W1);
        resp_o = 1'b1;
        step();
        resp_o = 1'b0;
        step();
        chk("drain_dequeued", write_i, 0);

        // Read hits a buffered line: served locally, no downstream read.
        rd0 = n_rd;
        dpmem_write = 1'b1; dpmem_address = 32'h4000; dpmem_wdata = AA;
        step();
        chk("wrA_resp", dpmem_resp, 1);
        dpmem_write = 1'b0; dpmem_read = 1'b1; dpmem_address = 32'h4010;
        step(); step();
        chk("hit_resp", dpmem_resp, 1);
        chk("hit_data", dpmem_rdata, AA);
        dpmem_read = 1'b0;
        step(); step();
        chk("hit_no_read_i", n_rd - rd0, 0);
        chk("drainA_addr", address_i, 32'h4000);
        resp_o = 1'b1;
        step();
        resp_o = 1'b0;

        // Three writes with depth 2: third waits for the oldest to drain.
        dpmem_write = 1'b1; dpmem_address = 32'h5000; dpmem_wdata = D5;
        step();
        chk("wr5_resp", dpmem_resp, 1);
        dpmem_address = 32'h6000; dpmem_wdata = D6;
        step(); step();
        chk("wr6_resp", dpmem_resp, 1);
        dpmem_address = 32'h7000; dpmem_wdata = D7;
        step(); step();
        chk("full_stall_resp", dpmem_resp, 0);
        chk("full_drain_addr", address_i, 32'h5000);
        chk("full_drain_line", line_i, D5);
        resp_o = 1'b1;
        step();
        resp_o = 1'b0;
        chk("full_no_resp_yet", dpmem_resp, 0);
        step();
        chk("wr7_resp", dpmem_resp, 1);
        dpmem_write = 1'b0;
        step(); step();
        chk("fifo_order_6", {write_i, address_i}, {1'b1, 32'h6000});
        resp_o = 1'b1;
        step();
        resp_o = 1'b0;
        step();
        chk("fifo_order_7", {write_i, address_i, line_i}, {1'b1, 32'h7000, D7});
        resp_o = 1'b1;
        step();
        resp_o = 1'b0;

        // Same line written twice: both kept, icache read sees the youngest.
        dpmem_write = 1'b1; dpmem_address = 32'h8000; dpmem_wdata = B1;
        step();
        chk("wrB1_resp", dpmem_resp, 1);
        dpmem_wdata = B2;
        step(); step();
        chk("wrB2_resp", dpmem_resp, 1);
        dpmem_write = 1'b0; ipmem_read = 1'b1; ipmem_address = 32'h8004;
        step(); step();
        chk("ihit_resp", ipmem_resp, 1);
        chk("ihit_youngest", ipmem_rdata, B2);
        ipmem_read = 1'b0;
        step(); step();
        chk("nodedup_first", {write_i, address_i, line_i}, {1'b1, 32'h8000, B1});
        resp_o = 1'b1;
        step();
        resp_o = 1'b0;
        step();
        chk("nodedup_second", {write_i, address_i, line_i}, {1'b1, 32'h8000, B2});
        resp_o = 1'b1;
        step();
        resp_o = 1'b0;

        // Reset during a pending DREAD with a buffered line.
        dpmem_write = 1'b1; dpmem_address = 32'hA000; dpmem_wdata = CC;
        step();
        dpmem_write = 1'b0; dpmem_read = 1'b1; dpmem_address = 32'h9000;
        step(); step();
        chk("pre_rst_dread", {read_i, address_i}, {1'b1, 32'h9000});
        rst = 1'b1;
        step();
        chk("mid_rst_outputs", {address_i, read_i, write_i, ipmem_resp, dpmem_resp}, 0);
        chk("mid_rst_line_i", line_i, 0);
        chk("mid_rst_rdata", ipmem_rdata | dpmem_rdata, 0);
        rst = 1'b0; dpmem_read = 1'b0;
        wr0 = n_wr;
        step(); step(); step();
        chk("rst_buf_empty", n_wr - wr0, 0);
        ipmem_read = 1'b1; ipmem_address = 32'hA000;
        step();
        chk("post_rst_iread", {read_i, address_i}, {1'b1, 32'hA000});
        resp_o = 1'b1; line_o = L3; #1;
        chk("post_rst_iresp", {ipmem_resp, ipmem_rdata}, {1'b1, L3});
        ipmem_read = 1'b0;
        step();
        resp_o = 1'b0; line_o = '0;

        chk("no_dual_resp", n_both, 0);
        chk("no_read_write", n_rw, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pmem_scheduler.md
PMEM_SCHEDULER -- requirements
Module: pmem_scheduler

Interface
REQ-001 SHALL have parameter WB_DEPTH, default 2, meaning the number of 256-bit dcache write-back buffer entries; legal values are 1 to 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports ipmem_address (input, 32), ipmem_read (input, 1), ipmem_rdata (output, 256) and ipmem_resp (output, 1) for the icache line-read requester.
REQ-005 SHALL have ports dpmem_address (input, 32), dpmem_read (input, 1), dpmem_write (input, 1), dpmem_wdata (input, 256), dpmem_rdata (output, 256) and dpmem_resp (output, 1) for the dcache requester.
REQ-006 SHALL have ports address_i (output, 32), read_i (output, 1), write_i (output, 1), line_i (output, 256), line_o (input, 256) and resp_o (input, 1) toward the cacheline adaptor.

Function
REQ-007 SHALL use an FSM with states IDLE, LOCAL_RESP, IREAD, DREAD and DRAIN.
REQ-008 SHALL evaluate requests only in IDLE, with this priority:
- dcache write and buffer not full: enqueue {addr[31:5], wdata}, go to LOCAL_RESP.
- dcache read: go to DREAD.
- icache read: go to IREAD.
- buffer non-empty: go to DRAIN.
REQ-009 SHALL, when a dcache write arrives with the buffer full, go to DRAIN and keep the write pending until an entry frees.
REQ-010 SHALL compare every read's address[31:5] against all valid buffer entries, for both icache and dcache reads.
- On a hit, return the youngest matching entry's data via LOCAL_RESP, with no downstream access.
REQ-011 SHALL spend exactly one cycle in LOCAL_RESP, pulsing the owning resp with rdata valid, then return to IDLE.
- Latency is 2 cycles from request to resp.
REQ-012 SHALL, in IREAD or DREAD, drive address_i = {addr[31:5], 5'b0} with read_i = 1.
- All downstream outputs SHALL be held stable until resp_o.
- On resp_o, SHALL pulse the requester's resp for one cycle with rdata = line_o in that same cycle, then go to IDLE.
REQ-013 SHALL, in DRAIN, issue the oldest entry with write_i = 1 and line_i = entry data.
- On resp_o, SHALL dequeue that entry and return to IDLE.
REQ-014 SHALL never assert read_i and write_i together, and SHALL never assert both ipmem_resp and dpmem_resp in the same cycle.
REQ-015 SHALL NOT deduplicate a dcache write to a line already buffered: a new entry is allocated and entries drain in FIFO order.
REQ-016 SHALL wrap the buffer pointers modulo WB_DEPTH and track count 0..WB_DEPTH.
- Full means count == WB_DEPTH; an enqueue and a dequeue cannot occur in the same cycle.
REQ-017 SHALL keep ipmem_rdata/dpmem_rdata unchanged except in their resp cycle (no valid-data guarantee outside resp).

Reset
REQ-018 SHALL, when rst is high at a clock edge, go to IDLE and empty the buffer.
- Reset values: address_i = 0, read_i = 0, write_i = 0, line_i = 0, both resps = 0, both rdata = 0.
REQ-019 SHALL abandon any in-flight downstream transaction on a reset mid-operation, and SHALL discard buffered write data.

Structure
REQ-020 SHALL place pmem_sched_state_t (FSM enum) and wb_entry_t (tag[26:0], data[255:0]) in package types.
REQ-021 SHALL implement the buffer as sub-module wb_fifo, which provides enqueue, dequeue, oldest-entry output and a parallel youngest-match lookup port.

Verification
REQ-022 Simultaneous icache read 0x100 and dcache read 0x2000 in IDLE -> dcache served first (read_i, address_i = 0x2000), then icache at 0x100.
REQ-023 dcache write 0x3020 with buffer empty -> dpmem_resp 2 cycles later, no downstream activity; the later idle cycle drains it with write_i, address_i = 0x3020.
REQ-024 Write line A = 0x4000 (data 0xAA..), then dcache read 0x4010 before the drain -> dpmem_resp with rdata = 0xAA.., and read_i never asserted.
REQ-025 WB_DEPTH = 2: three back-to-back writes to 0x5000, 0x6000 and 0x7000 -> the third stalls, 0x5000 drains, then the third is accepted.
REQ-026 Assert rst in DREAD while resp_o is pending -> next cycle all outputs are 0, the buffer is empty, and a new icache read proceeds normally.
REQ-027 Stall resp_o for 10 cycles in IREAD -> address_i and read_i stay stable, and ipmem_resp pulses exactly once.
